// File: rtl/puf_auth_ctrl.sv
// PUF authentication controller: runs eight ring-oscillator comparison rounds,
// assembles an 8-bit response and scores it against the enrolled reference.
`timescale 1ns/1ps

module puf_auth_ctrl #(
  parameter int unsigned WIN_CYCLES = 255,
  parameter int unsigned THRESH     = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [4:0] seed,
  input  logic [7:0] expected,
  input  logic [7:0] count_a,
  input  logic [7:0] count_b,
  output logic       puf_clr,
  output logic       puf_ena,
  output logic [4:0] challenge,
  output logic       busy,
  output logic       done,
  output logic [7:0] resp,
  output logic [3:0] hd,
  output logic       pass
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CLEAR  = 3'd1;
  localparam logic [2:0] S_MEAS   = 3'd2;
  localparam logic [2:0] S_SETTLE = 3'd3;
  localparam logic [2:0] S_SAMPLE = 3'd4;
  localparam logic [2:0] S_EVAL   = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;

  localparam logic [15:0] WIN_LAST = 16'(WIN_CYCLES - 1);
  localparam logic [3:0]  THRESH_Q = 4'(THRESH);

  logic [2:0]  state;
  logic [4:0]  seed_q;
  logic [7:0]  exp_q;
  logic [2:0]  k;
  logic [15:0] win_cnt;
  logic [3:0]  hd_next;

  always_comb begin
    hd_next = '0;
    for (int i = 0; i < 8; i++) begin
      hd_next = hd_next + {3'b000, resp[i] ^ exp_q[i]};
    end
  end

  // Control outputs are registered decodes of the current state, so they trail
  // the FSM by one cycle; SAMPLE therefore sees two full cycles of disabled oscillators.
  // NOTE: every register here uses non-blocking assignments so all flops update
  // together on the edge and simulation matches the synthesized netlist.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      seed_q    <= '0;
      exp_q     <= '0;
      k         <= '0;
      win_cnt   <= '0;
      puf_clr   <= 1'b0;
      puf_ena   <= 1'b0;
      challenge <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      resp      <= '0;
      hd        <= '0;
      pass      <= 1'b0;
    end else begin
      puf_clr <= (state == S_CLEAR);
      puf_ena <= (state == S_MEAS);
      busy    <= (state != S_IDLE);
      done    <= (state == S_DONE);

      case (state)
        S_IDLE: begin
          if (start) begin
            seed_q  <= seed;
            exp_q   <= expected;
            resp    <= '0;
            hd      <= '0;
            pass    <= 1'b0;
            k       <= '0;
            win_cnt <= '0;
            state   <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          challenge <= seed_q + {2'b00, k};
          win_cnt   <= '0;
          state     <= S_MEAS;
        end
        S_MEAS: begin
          if (win_cnt == WIN_LAST) begin
            win_cnt <= '0;
            state   <= S_SETTLE;
          end else begin
            win_cnt <= win_cnt + 16'd1;
          end
        end
        S_SETTLE: begin
          // The window counter is reused to time the two settle cycles.
          if (win_cnt == 16'd1) begin
            win_cnt <= '0;
            state   <= S_SAMPLE;
          end else begin
            win_cnt <= win_cnt + 16'd1;
          end
        end
        S_SAMPLE: begin
          resp[k] <= (count_a > count_b);
          if (k == 3'd7) begin
            state <= S_EVAL;
          end else begin
            k     <= k + 3'd1;
            state <= S_CLEAR;
          end
        end
        S_EVAL: begin
          hd    <= hd_next;
          pass  <= (hd_next <= THRESH_Q);
          state <= S_DONE;
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_puf_auth_ctrl.sv
// Scoreboard bench for puf_auth_ctrl: predicted run results are queued at start
// and checked, together with per-round PUF control activity, when done pulses.
`timescale 1ns/1ps

module tb_puf_auth_ctrl;

  localparam int WIN    = 4;
  localparam int THRESH = 2;
  localparam int ROUND  = WIN + 4;
  localparam int LAT    = 8 * ROUND + 2;

  typedef struct {
    int         acc;
    logic [4:0] seed;
    logic [7:0] resp;
    logic [3:0] hd;
    logic       pass;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic [4:0] seed = '0;
  logic [7:0] expected = '0;
  logic [7:0] count_a = '0;
  logic [7:0] count_b = '0;
  logic       puf_clr, puf_ena, busy, done, pass;
  logic [4:0] challenge;
  logic [7:0] resp;
  logic [3:0] hd;

  logic [7:0] ca_e, cb_e, ca_o, cb_o;
  int         cyc = 0;
  int         n_checks = 0;
  int         n_err = 0;

  exp_t       sb[$];
  exp_t       mon_x;
  logic [4:0] ch_exp;
  int         busy_low, clr_cnt, ena_rounds, ena_run, overlap, rnd;
  int         done_pulses = 0;

  puf_auth_ctrl #(.WIN_CYCLES(WIN), .THRESH(THRESH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .seed(seed), .expected(expected),
    .count_a(count_a), .count_b(count_b), .puf_clr(puf_clr), .puf_ena(puf_ena),
    .challenge(challenge), .busy(busy), .done(done), .resp(resp), .hd(hd), .pass(pass)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
    n_checks++;
    if (obs !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, req, cyc);
    end
  endtask

  function automatic exp_t make_exp(input int acc, input logic [4:0] s, input logic [7:0] e);
    exp_t x;
    x.acc  = acc;
    x.seed = s;
    x.resp = '0;
    for (int r = 0; r < 8; r++) x.resp[r] = (r % 2 == 1) ? (ca_o > cb_o) : (ca_e > cb_e);
    x.hd = '0;
    for (int r = 0; r < 8; r++) x.hd = x.hd + {3'b000, x.resp[r] ^ e[r]};
    x.pass = (x.hd <= 4'(THRESH));
    return x;
  endfunction

  task automatic drive_counts(input int acc);
    int r;
    r = (cyc - acc) / ROUND;
    if (r < 0) r = 0;
    if (r % 2 == 1) begin
      count_a = ca_o; count_b = cb_o;
    end else begin
      count_a = ca_e; count_b = cb_e;
    end
  endtask

  task automatic clear_mon();
    busy_low = 0; clr_cnt = 0; ena_rounds = 0; ena_run = 0; overlap = 0; rnd = 0;
  endtask

  // Monitor: tracks control activity of the run at the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      clear_mon();
    end else begin
      if (sb.size() > 0 && cyc > sb[0].acc) begin
        if (!busy) busy_low++;
        if (puf_clr && puf_ena) overlap++;
        if (puf_clr) begin
          ch_exp = sb[0].seed + 5'(rnd);
          check("challenge", 32'(challenge), 32'(ch_exp));
          clr_cnt++;
          rnd++;
        end
        if (puf_ena) begin
          ena_run++;
        end else if (ena_run != 0) begin
          check("ena_width", ena_run, WIN);
          ena_rounds++;
          ena_run = 0;
        end
      end
      if (done) begin
        done_pulses++;
        if (sb.size() == 0) begin
          check("spurious_done", 32'(done), 32'(0));
        end else begin
          mon_x = sb.pop_front();
          check("resp", 32'(resp), 32'(mon_x.resp));
          check("hd", 32'(hd), 32'(mon_x.hd));
          check("pass", 32'(pass), 32'(mon_x.pass));
          check("latency", cyc - mon_x.acc, LAT);
          check("busy_low_in_run", busy_low, 0);
          check("clr_pulses", clr_cnt, 8);
          check("ena_rounds", ena_rounds, 8);
          check("clr_ena_overlap", overlap, 0);
          clear_mon();
        end
      end
    end
  end

  task automatic set_counts(input logic [7:0] ae, input logic [7:0] be,
                            input logic [7:0] ao, input logic [7:0] bo);
    ca_e = ae; cb_e = be; ca_o = ao; cb_o = bo;
  endtask

  // One run from a start pulse; a stray start with different seed/expected is
  // injected mid-run and must be ignored.
  task automatic run_once(input logic [4:0] s, input logic [7:0] e);
    int acc, n0;
    bit got;
    @(negedge clk);
    seed = s; expected = e; start = 1'b1;
    acc = cyc + 1;
    sb.push_back(make_exp(acc, s, e));
    n0 = done_pulses;
    drive_counts(acc);
    got = 1'b0;
    for (int i = 0; i < LAT + 20; i++) begin
      @(negedge clk);
      start    = (cyc == acc + 20);
      seed     = (cyc == acc + 20) ? ~s : s;
      expected = (cyc == acc + 20) ? ~e : e;
      drive_counts(acc);
      if (done_pulses > n0) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) check("run_timeout", done_pulses - n0, 1);
    start = 1'b0;
  endtask

  initial begin
    int acc, a1, n0, d0;
    set_counts(8'd0, 8'd0, 8'd0, 8'd0);
    clear_mon();
    #2 rst_n = 1'b0;
    #1;
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_clr", 32'(puf_clr), 0);
    check("rst_ena", 32'(puf_ena), 0);
    check("rst_challenge", 32'(challenge), 0);
    check("rst_resp", 32'(resp), 0);
    check("rst_hd", 32'(hd), 0);
    check("rst_pass", 32'(pass), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // All rounds win, perfect match; results and challenge must then hold.
    set_counts(8'd10, 8'd5, 8'd10, 8'd5);
    run_once(5'd3, 8'hFF);
    repeat (5) @(negedge clk);
    check("resp_hold", 32'(resp), 32'h0000_00FF);
    check("challenge_hold", 32'(challenge), 32'd10);
    check("idle_busy", 32'(busy), 0);

    // Ties always give 0.
    set_counts(8'd7, 8'd7, 8'd7, 8'd7);
    run_once(5'd17, 8'h0F);

    // Challenge wraps 30,31,0,...; maximum distance 8.
    set_counts(8'd10, 8'd5, 8'd10, 8'd5);
    run_once(5'd30, 8'h00);

    // Odd rounds only; distances 1, 2 (threshold) and 3.
    set_counts(8'd3, 8'd9, 8'd9, 8'd3);
    run_once(5'd5, 8'hAB);
    run_once(5'd6, 8'hA9);
    run_once(5'd7, 8'hAD);

    // Unsigned compare across the sign boundary.
    set_counts(8'h80, 8'h7F, 8'h80, 8'h7F);
    run_once(5'd0, 8'hF0);

    // Reset in round 3 during the measurement window.
    set_counts(8'd10, 8'd5, 8'd10, 8'd5);
    @(negedge clk);
    seed = 5'd9; expected = 8'h12; start = 1'b1;
    acc = cyc + 1;
    sb.push_back(make_exp(acc, 5'd9, 8'h12));
    @(negedge clk);
    start = 1'b0;
    while (cyc < acc + 3 * ROUND + 3) @(negedge clk);
    check("pre_rst_ena", 32'(puf_ena), 1);
    check("pre_rst_resp", 32'(resp), 32'h07);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_ena", 32'(puf_ena), 0);
    check("mid_rst_clr", 32'(puf_clr), 0);
    check("mid_rst_resp", 32'(resp), 0);
    check("mid_rst_done", 32'(done), 0);
    check("mid_rst_challenge", 32'(challenge), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    d0 = done_pulses;
    repeat (LAT + 10) @(negedge clk);
    check("no_done_after_rst", done_pulses - d0, 0);
    run_once(5'd9, 8'h12);

    // Start held high: three back-to-back runs, each restarting the cycle after done.
    @(negedge clk);
    seed = 5'd12; expected = 8'h3C; start = 1'b1;
    a1 = cyc + 1;
    for (int i = 0; i < 3; i++) sb.push_back(make_exp(a1 + i * (LAT + 1), 5'd12, 8'h3C));
    n0 = done_pulses;
    for (int i = 0; i < 3 * (LAT + 1) + 20; i++) begin
      @(negedge clk);
      if (cyc >= a1 + 2 * (LAT + 1)) start = 1'b0;
      drive_counts(a1);
      if (done_pulses >= n0 + 3) break;
    end
    check("held_runs", done_pulses - n0, 3);
    repeat (LAT + 10) @(negedge clk);
    check("held_no_extra_run", done_pulses - n0, 3);
    check("held_idle_busy", 32'(busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule

// File: doc/puf_auth_ctrl.md
PUF_AUTH_CTRL -- requirements
Module: puf_auth_ctrl

Interface
REQ-001 The block SHALL have parameter WIN_CYCLES, default 255: clk cycles per oscillator measurement window, legal range 1..65535.
REQ-002 The block SHALL have parameter THRESH, default 2: maximum Hamming distance that still counts as a pass, legal range 0..8.
REQ-003 The block SHALL have port clk  in  1: the single clock; all flops in the block SHALL be clocked by it.
REQ-004 The block SHALL have port rst_n  in  1: asynchronous, active-low reset.
REQ-005 The block SHALL have port start  in  1: request an authentication run; sampled only in IDLE.
REQ-006 The block SHALL have port seed  in  5: first challenge of the run; captured when start is accepted.
REQ-007 The block SHALL have port expected  in  8: enrolled reference response; captured when start is accepted.
REQ-008 The block SHALL have port count_a  in  8: ring-oscillator counter A value from the PUF array.
REQ-009 The block SHALL have port count_b  in  8: ring-oscillator counter B value from the PUF array.
REQ-010 The block SHALL have port puf_clr  out  1: clears the PUF counters.
REQ-011 The block SHALL have port puf_ena  out  1: enables the oscillators.
REQ-012 The block SHALL have port challenge  out  5: oscillator-select challenge driven to the PUF.
REQ-013 The block SHALL have port busy  out  1: high while a run is in progress.
REQ-014 The block SHALL have port done  out  1: single-cycle pulse when the run results are valid.
REQ-015 The block SHALL have port resp  out  8: collected response bits.
REQ-016 The block SHALL have port hd  out  4: Hamming distance between resp and expected.
REQ-017 The block SHALL have port pass  out  1: authentication verdict.

Function
REQ-018 The FSM SHALL have the states IDLE, CLEAR, MEAS, SETTLE, SAMPLE, EVAL and DONE.
REQ-019 In IDLE, start=1 at a clk edge SHALL capture seed and expected, clear resp, hd and pass, set the round index k=0, and move the FSM to CLEAR.
REQ-020 CLEAR SHALL last 1 cycle with puf_clr=1, puf_ena=0 and challenge=(seed+k) mod 32.
REQ-021 MEAS SHALL last exactly WIN_CYCLES cycles with puf_ena=1, puf_clr=0 and challenge held; a 16-bit window counter SHALL time the window.
REQ-022 SETTLE SHALL last 2 cycles with puf_ena=0 and challenge held, to let the counters settle.
REQ-023 SAMPLE SHALL last 1 cycle and write resp[k] = (count_a > count_b), unsigned compare; a tie SHALL give 0.
REQ-024 After SAMPLE, if k<7 the FSM SHALL increment k and go to CLEAR; if k=7 it SHALL go to EVAL.
REQ-025 Each round SHALL take WIN_CYCLES+4 cycles, and round 0 SHALL fill resp[0] (LSB first).
REQ-026 EVAL SHALL last 1 cycle and register hd = popcount(resp XOR expected) (0..8) and pass = (hd <= THRESH).
REQ-027 DONE SHALL last 1 cycle with done=1 and SHALL return to IDLE on the next edge.
REQ-028 Total run latency SHALL be 8*(WIN_CYCLES+4)+2 cycles, measured from the start-accept edge to the edge that makes done=1 visible.
REQ-029 busy SHALL be 1 in every state except IDLE, including during DONE.
REQ-030 start SHALL be ignored in every state except IDLE.
REQ-031 start held high SHALL begin a new run on the first IDLE cycle after DONE.
REQ-032 resp, hd and pass SHALL hold their values after DONE until the next accepted start.
REQ-033 challenge SHALL hold its last value in IDLE.
REQ-034 Challenge arithmetic SHALL be 5-bit modulo 32, so seed 31 is followed by challenge 0.
REQ-035 puf_ena and puf_clr SHALL never be 1 at the same time.
REQ-036 All outputs SHALL be registered.

Reset
REQ-037 rst_n=0 SHALL, without waiting for a clk edge, force the FSM to IDLE and set puf_clr, puf_ena, challenge, busy, done, resp, hd, pass, k and the window counter to 0.
REQ-038 Reset during any state, including mid-MEAS, SHALL abort the run, with no done pulse and all partial results discarded.
REQ-039 After rst_n returns high, the first start SHALL be accepted normally.

Verification (WIN_CYCLES=4, THRESH=2)
REQ-040 Bench SHALL cover: count_a=10, count_b=5 constant, expected=0xFF, start pulse -> resp=0xFF, hd=0, pass=1, exactly one done pulse at 66 cycles after accept, and busy high throughout.
REQ-041 Bench SHALL cover: count_a=count_b=7 constant, expected=0x0F -> resp=0x00, hd=4, pass=0.
REQ-042 Bench SHALL cover: seed=30 -> per-round challenge sequence 30,31,0,1,2,3,4,5, with puf_clr high for exactly 1 cycle and puf_ena high for exactly 4 cycles per round, never overlapping.
REQ-043 Bench SHALL cover: count_a>count_b only in odd rounds, expected=0xAB -> resp=0xAA, hd=1, pass=1.
REQ-044 Bench SHALL cover: rst_n pulsed low in round 3 during MEAS -> immediately busy=0, puf_ena=0, resp=0 and no done; a subsequent start completes a full run.
REQ-045 Bench SHALL cover: start held high for 3 runs -> start pulses during busy have no effect and each run restarts on the IDLE cycle after DONE.
